// File: rtl/node_cnt_rmw_pkg.sv
// Shared definitions for the per-node counter read-modify-write controller.
package node_cnt_rmw_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned CNT_WIDTH_DEF = 8;

endpackage

// File: rtl/node_cnt_rmw_alu.sv
// Saturating counter update: computes the new count and an error flag for inc/dec at the limits.
module cnt_sat_alu
  import node_cnt_rmw_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic [CNT_WIDTH-1:0] old,
  input  op_e                  op,
  output logic [CNT_WIDTH-1:0] nv,
  output logic                 err
);

  always_comb begin
    nv  = old;
    err = 1'b0;
    case (op)
      OP_READ: ;
      OP_INC: begin
        if (old == '1) err = 1'b1;
        else           nv  = old + 1'b1;
      end
      OP_DEC: begin
        if (old == '0) err = 1'b1;
        else           nv  = old - 1'b1;
      end
      OP_CLR: nv = '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/node_cnt_rmw.sv
// Per-node packet counter RMW controller for one vPIFO tree level:
// post-reset clear sweep, then a 3-stage accept/update/respond pipeline over a write-first RAM.
module node_cnt_rmw
  import node_cnt_rmw_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [CNT_WIDTH-1:0]  resp_cnt,
  output logic                  resp_err,
  output logic                  init_done,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [CNT_WIDTH-1:0]  ram_data_a,
  output logic                  ram_re_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [CNT_WIDTH-1:0]  ram_data_b
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  logic                  accept;
  logic                  s1_valid;
  op_e                   s1_op;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [CNT_WIDTH-1:0]  nv;
  logic                  alu_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase
  end

  assign req_ready = (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);
  assign accept    = req_valid & req_ready;

  assign ram_re_en  = accept;
  assign ram_addr_b = accept ? req_addr : '0;

  // Sweep writes are masked while rst is held so every output reads 0 during reset.
  always_comb begin
    ram_wr_en  = 1'b0;
    ram_addr_a = '0;
    ram_data_a = '0;
    if (state_q == ST_INIT && !rst) begin
      ram_wr_en  = 1'b1;
      ram_addr_a = ptr_q;
    end else if (s1_valid && s1_op != OP_READ) begin
      ram_wr_en  = 1'b1;
      ram_addr_a = s1_addr;
      ram_data_a = nv;
    end
  end

  cnt_sat_alu #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_alu (
    .old (ram_data_b),
    .op  (s1_op),
    .nv  (nv),
    .err (alu_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_READ;
      s1_addr  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op   <= op_e'(req_op);
        s1_addr <= req_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      resp_cnt   <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_addr <= s1_addr;
        resp_cnt  <= nv;
        resp_err  <= alu_err;
      end
    end
  end

endmodule

// File: tb/tb_node_cnt_rmw.sv
// Directed bench for node_cnt_rmw with a write-first dual-port RAM model attached.
module tb_node_cnt_rmw;
  import node_cnt_rmw_pkg::*;

  localparam int AW = 4;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic [AW-1:0] resp_addr;
  logic [CW-1:0] resp_cnt;
  logic          resp_err;
  logic          init_done;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr_a;
  logic [CW-1:0] ram_data_a;
  logic          ram_re_en;
  logic [AW-1:0] ram_addr_b;
  logic [CW-1:0] ram_data_b;

  node_cnt_rmw #(
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_addr  (resp_addr),
    .resp_cnt   (resp_cnt),
    .resp_err   (resp_err),
    .init_done  (init_done),
    .ram_wr_en  (ram_wr_en),
    .ram_addr_a (ram_addr_a),
    .ram_data_a (ram_data_a),
    .ram_re_en  (ram_re_en),
    .ram_addr_b (ram_addr_b),
    .ram_data_b (ram_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0] mem [16];

  always @(posedge clk) begin
    if (ram_re_en)
      ram_data_b <= (ram_wr_en && ram_addr_a == ram_addr_b) ? ram_data_a : mem[ram_addr_b];
    if (ram_wr_en)
      mem[ram_addr_a] <= ram_data_a;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]    q_op   [32];
  logic [AW-1:0] q_addr [32];
  logic [CW-1:0] q_cnt  [32];
  logic          q_err  [32];
  int            q_n;

  task automatic set_vec(input int i, input op_e op, input logic [AW-1:0] a,
                         input logic [CW-1:0] cnt, input logic err);
    q_op[i]   = op;
    q_addr[i] = a;
    q_cnt[i]  = cnt;
    q_err[i]  = err;
  endtask

  // Issues q_op/q_addr one per cycle and expects each response exactly two cycles later.
  task automatic run_seq(input string tag);
    for (int c = 0; c < q_n + 2; c++) begin
      if (c < q_n) begin
        req_valid = 1'b1;
        req_op    = q_op[c];
        req_addr  = q_addr[c];
        #1;
        check({tag, "_re_en"}, ram_re_en, 1);
        check({tag, "_addr_b"}, ram_addr_b, q_addr[c]);
      end else begin
        req_valid = 1'b0;
      end
      if (c >= 2) begin
        check({tag, "_resp_valid"}, resp_valid, 1);
        check({tag, "_resp_addr"}, resp_addr, q_addr[c-2]);
        check({tag, "_resp_cnt"}, resp_cnt, q_cnt[c-2]);
        check({tag, "_resp_err"}, resp_err, q_err[c-2]);
      end else begin
        check({tag, "_early_resp"}, resp_valid, 0);
      end
      tick();
    end
    req_valid = 1'b0;
    check({tag, "_resp_end"}, resp_valid, 0);
  endtask

  // Called with rst just released and combinational outputs settled.
  task automatic init_sweep_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_wr_en"}, ram_wr_en, 1);
      check({tag, "_wr_addr"}, ram_addr_a, i);
      check({tag, "_wr_data"}, ram_data_a, 0);
      check({tag, "_done_low"}, init_done, 0);
      check({tag, "_ready_low"}, req_ready, 0);
      check({tag, "_no_resp"}, resp_valid, 0);
      tick();
    end
    check({tag, "_done"}, init_done, 1);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_wr_idle"}, ram_wr_en, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = '0;
    tick();
    tick();
    check("rst_wr_en", ram_wr_en, 0);
    check("rst_re_en", ram_re_en, 0);
    check("rst_ready", req_ready, 0);
    check("rst_done", init_done, 0);
    check("rst_resp", resp_valid, 0);
    rst = 1'b0;
    #1;
    init_sweep_check("init");
    tick();
    tick();

    q_n = 4;
    set_vec(0, OP_INC, 4'd3, 8'd1, 1'b0);
    set_vec(1, OP_INC, 4'd3, 8'd2, 1'b0);
    set_vec(2, OP_INC, 4'd3, 8'd3, 1'b0);
    set_vec(3, OP_READ, 4'd3, 8'd3, 1'b0);
    run_seq("inc3");
    tick();

    q_n = 2;
    set_vec(0, OP_DEC, 4'd5, 8'd0, 1'b1);
    set_vec(1, OP_INC, 4'd5, 8'd1, 1'b0);
    run_seq("dec5");
    tick();

    for (int i = 0; i < 255; i++) begin
      req_valid = 1'b1;
      req_op    = OP_INC;
      req_addr  = 4'd7;
      tick();
    end
    req_valid = 1'b0;
    tick();
    tick();
    q_n = 3;
    set_vec(0, OP_INC, 4'd7, 8'd255, 1'b1);
    set_vec(1, OP_CLR, 4'd7, 8'd0, 1'b0);
    set_vec(2, OP_READ, 4'd7, 8'd0, 1'b0);
    run_seq("sat7");
    tick();

    q_n = 4;
    set_vec(0, OP_INC, 4'd2, 8'd1, 1'b0);
    set_vec(1, OP_INC, 4'd9, 8'd1, 1'b0);
    set_vec(2, OP_DEC, 4'd2, 8'd0, 1'b0);
    set_vec(3, OP_READ, 4'd9, 8'd1, 1'b0);
    run_seq("mix");
    tick();

    req_valid = 1'b1;
    req_op    = OP_INC;
    req_addr  = 4'd4;
    tick();
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("midrst_wr_en", ram_wr_en, 0);
    check("midrst_resp", resp_valid, 0);
    tick();
    check("midrst_resp2", resp_valid, 0);
    rst = 1'b0;
    #1;
    init_sweep_check("reinit");
    tick();
    tick();
    q_n = 1;
    set_vec(0, OP_READ, 4'd4, 8'd0, 1'b0);
    run_seq("rd4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/node_cnt_rmw.md
Name: node_cnt_rmw

Overview:
- Read-modify-write controller for per-node packet counters of one vPIFO tree level.
- Drives the write port and read port of the level's simple dual-port counter RAM, and consumes its 1-cycle read data.
- Sits between the tree-level scheduler (which issues inc/dec/read/clear on a node address) and the counter RAM.
- Performs a post-reset clear sweep of the RAM, because the RAM's own reset is not relied on for contents.

Parameters:
- ADDR_WIDTH, 4, node address width.
- CNT_WIDTH, 8, counter width.
- DEPTH, 2**ADDR_WIDTH, number of node entries swept at init.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  2  00 read, 01 inc, 10 dec, 11 clear.
- req_addr  in  ADDR_WIDTH  node index.
- resp_valid  out  1  one-cycle response strobe; no backpressure.
- resp_addr  out  ADDR_WIDTH  node index of the response.
- resp_cnt  out  CNT_WIDTH  counter value after the operation.
- resp_err  out  1  inc at max or dec at zero; counter saturates.
- init_done  out  1  high once the clear sweep has completed.
- ram_wr_en  out  1  RAM write enable.
- ram_addr_a  out  ADDR_WIDTH  RAM write address.
- ram_data_a  out  CNT_WIDTH  RAM write data.
- ram_re_en  out  1  RAM read enable.
- ram_addr_b  out  ADDR_WIDTH  RAM read address.
- ram_data_b  in  CNT_WIDTH  RAM read data, valid 1 cycle after ram_re_en.
- The RAM returns the write data when the read and write addresses match in the same cycle (write-first).

Behaviour:
- Reset state:
  - All outputs 0.
  - FSM enters INIT with sweep pointer at 0.
  - Pipeline valid bits cleared.
- FSM INIT:
  - Each cycle: ram_wr_en=1, ram_addr_a=ptr, ram_data_a=0, then ptr increments.
  - At ptr==DEPTH-1 the FSM goes to RUN the next cycle.
  - Duration is exactly DEPTH cycles. req_ready=0 and init_done=0 throughout.
- FSM RUN:
  - req_ready=1 every cycle.
  - init_done=1 from the first RUN cycle and stays high until reset.
- Stage 0, accept at cycle t:
  - ram_re_en=1 combinationally and ram_addr_b=req_addr.
  - Op and address are registered into stage 1.
  - The RAM-facing outputs are combinational from req_* gated by the handshake.
- Stage 1, cycle t+1, new value nv computed from ram_data_b:
  - read: nv=old.
  - inc: nv=old+1; if old=all-ones, nv=old and err=1.
  - dec: nv=old-1; if old=0, nv=0 and err=1.
  - clear: nv=0; ram_data_b is ignored.
  - For inc, dec and clear: ram_wr_en=1, ram_addr_a=stage-1 addr, ram_data_a=nv. For read, no write.
- Stage 2, cycle t+2:
  - resp_valid=1 with registered resp_addr, resp_cnt=nv and resp_err.
  - Latency from accept to response is 2 cycles.
- Back-to-back requests:
  - Full rate: 1 request per cycle.
  - A request accepted at t+1 to the same address as the stage-1 write reads through the RAM's same-cycle bypass, so it sees the updated count. No extra forwarding logic is added in this block.
- Counter arithmetic is modulo-free: saturating only, never wraps.
- resp_valid stays low in cycles with no corresponding accepted request.
- Reset asserted mid-operation:
  - In-flight stage-1 writes and stage-2 responses are dropped.
  - The FSM restarts INIT from ptr 0.

Decomposition:
- Shared package holds:
  - op encodings OP_READ/OP_INC/OP_DEC/OP_CLR;
  - FSM state encodings ST_INIT/ST_RUN;
  - the tree-level CNT_WIDTH default.
- Natural sub-module: cnt_sat_alu, purely combinational (old, op → nv, err).
- The FSM and pipeline stay in the top module.

Test Plan:
- Reset, then idle: ram_wr_en high for exactly 16 cycles with addresses 0..15 and data 0. init_done rises at cycle 16. No resp_valid.
- inc addr 3 three times back-to-back, then read 3: responses 1, 2, 3, 3 on four consecutive cycles, each 2 cycles after its accept. The same-address bypass is exercised.
- dec addr 5 from 0: resp_cnt=0, resp_err=1, no change to RAM contents. Then inc 5 → 1 with err=0.
- Preload addr 7 to 255 via 255 incs, then inc: resp_cnt=255, resp_err=1. Then clear 7 → 0, then read 7 → 0.
- Interleave inc 2, inc 9, dec 2, read 9 every cycle: responses (2,1), (9,1), (2,0), (9,1). ram_re_en asserted every cycle.
- Assert rst one cycle after accepting inc 4:
  - no resp_valid;
  - INIT sweep restarts from 0;
  - after init, read 4 → 0.
